mfp_srec_ahb_loader_master: RTL and testbench
=============================================

// Module: mfp_srec_ahb_loader_master
// PURPOSE
//  Second-generation serial-load AHB-Lite write master. Sits between the
//  SREC parser byte stream and the AHB-Lite bus mux. Merges bytes that hit
//  the same word into single word writes, buffers them in a FIFO, and
//  issues HREADY-aware transfers. Also checks an address window and reports
//  status, so the loader tolerates wait-stated slaves.
// PARAMETERS
//  FIFO_DEPTH    16            entries of {addr[31:2],data[31:0],mask[3:0]}; power of 2, >=2
//  WIN_BASE      32'h00000000  lowest byte address accepted
//  WIN_LOG2      32            window size = 2**WIN_LOG2 bytes; 32 = whole space
//  FLUSH_CYCLES  64            idle cycles before a partial pack entry is pushed; >=1
// PORTS
//  HCLK             in   1   clock
//  HRESET           in   1   synchronous reset, active-high
//  SI_Endian        in   1   1 = big-endian lane order
//  in_progress      in   1   parser load active
//  write_address    in   32  byte address from parser
//  write_byte       in   8   byte data from parser
//  write_enable     in   1   one-cycle strobe: byte valid
//  HREADY           in   1   bus ready (slave mux output)
//  HADDR            out  32  AHB address
//  HBURST           out  3   always 3'b000 (SINGLE)
//  HMASTLOCK        out  1   always 0
//  HPROT            out  4   always 4'b0011
//  HSIZE            out  3   3'b000 byte / 3'b010 word
//  HTRANS           out  2   2'b00 IDLE / 2'b10 NONSEQ
//  HWDATA           out  32  write data (data phase)
//  HWRITE           out  1   1 in address phase, else 0
//  bus_owner        out  1   in_progress | pack valid | FIFO non-empty | FSM!=IDLE
//  overflow_err     out  1   sticky: byte dropped because FIFO full
//  range_err        out  1   sticky: byte dropped because outside window
//  xfer_count       out  16  completed AHB transfers, wraps at 16'hFFFF->0
// BEHAVIOUR
//  Reset: all outputs 0 except HPROT=4'b0011; pack, FIFO, counters cleared.
//  Reset mid-transfer aborts; HTRANS=IDLE from the next cycle.
//  In-window test: (write_address - WIN_BASE) < 2**WIN_LOG2 (33-bit compare).
//  Out-of-window bytes are dropped and set range_err.
//  Pack stage (one entry): on write_enable with an in-window byte:
//   - pack empty: load addr[31:2], set the lane bit, store the byte.
//   - same word and lane bit clear: merge the byte.
//   - otherwise (other word, or lane already set): push pack, then load the byte.
//   - mask becomes 4'b1111: push in the same cycle.
//  Lane = addr[1:0] if SI_Endian=0, else 3-addr[1:0]; lane n = data[8n+7:8n].
//  Partial pack is pushed after FLUSH_CYCLES cycles with no write_enable,
//  and on the in_progress falling edge.
//  Push into a full FIFO: entry dropped, overflow_err set.
//  Simultaneous pop and push on a full FIFO is allowed (no overflow).
//  Sticky errors and xfer_count clear on the in_progress rising edge.
//  Master FSM:
//   IDLE -> ADDR when FIFO non-empty; pop the head entry.
//   ADDR: HTRANS=NONSEQ, HWRITE=1, HADDR/HSIZE set. Hold until HREADY=1,
//         then -> DATA.
//   DATA: HTRANS=IDLE, HWDATA valid. Hold until HREADY=1, then xfer_count+1.
//         Next -> ADDR if lanes remain in the entry, else -> IDLE
//         (or -> ADDR with the next FIFO entry).
//  mask=4'b1111: one word transfer, HADDR={addr,2'b00}, HWDATA=packed word.
//  Other masks: one byte transfer per set lane, lowest lane first.
//   HADDR low bits = byte offset of that lane; HWDATA = byte replicated x4.
//  Minimum cost is 2 cycles per transfer (no address/data overlap).
//  HRESP is ignored.
// TESTING
//  1 Bytes 11,22,33,44 to 0x100..0x103, LE, HREADY=1 -> one word write:
//    HADDR=0x100, HSIZE=010, HWDATA=0x44332211, xfer_count=1.
//  2 Same bytes with SI_Endian=1 -> HWDATA=0x11223344.
//  3 Single byte 0xAB to 0x205, then idle FLUSH_CYCLES -> byte write:
//    HADDR=0x205, HSIZE=000, HWDATA=0xABABABAB.
//  4 HREADY low 3 cycles in ADDR and 2 cycles in DATA -> HADDR/HTRANS and
//    HWDATA held stable, exactly one transfer counted.
//  5 HREADY=0 constantly, FIFO_DEPTH+3 distinct words streamed ->
//    overflow_err=1, bus_owner=1; on in_progress rise -> overflow_err=0.
//  6 WIN_BASE=0x1000, WIN_LOG2=12, byte to 0x2000 -> range_err=1,
//    no transfer; HRESET mid-ADDR -> HTRANS=00 next cycle, FIFO empty.

Source files
------------

// File: rtl/mfp_srec_ahb_loader_master.sv
// Serial-load AHB-Lite write master: packs parser bytes into word entries,
// queues them in a FIFO and replays them as HREADY-aware single transfers.
module mfp_srec_ahb_loader_master #(
    parameter int          FIFO_DEPTH   = 16,
    parameter logic [31:0] WIN_BASE     = 32'h0000_0000,
    parameter int          WIN_LOG2     = 32,
    parameter int          FLUSH_CYCLES = 64
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        SI_Endian,
    input  logic        in_progress,
    input  logic [31:0] write_address,
    input  logic [7:0]  write_byte,
    input  logic        write_enable,
    input  logic        HREADY,
    output logic [31:0] HADDR,
    output logic [2:0]  HBURST,
    output logic        HMASTLOCK,
    output logic [3:0]  HPROT,
    output logic [2:0]  HSIZE,
    output logic [1:0]  HTRANS,
    output logic [31:0] HWDATA,
    output logic        HWRITE,
    output logic        bus_owner,
    output logic        overflow_err,
    output logic        range_err,
    output logic [15:0] xfer_count
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);
    localparam logic [32:0]      WIN_SIZE   = 33'd1 << WIN_LOG2;
    localparam logic [PTR_W:0]   FIFO_FULL  = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    function automatic logic [1:0] low_lane(input logic [3:0] mask);
        logic [1:0] lane;
        casez (mask)
            4'b???1: lane = 2'd0;
            4'b??10: lane = 2'd1;
            4'b?100: lane = 2'd2;
            default: lane = 2'd3;
        endcase
        return lane;
    endfunction

    // Input qualification
    logic        in_prog_d_r;
    logic        rise_s, fall_s;
    logic [31:0] offset_s;
    logic        in_win_s, byte_ok_s, range_drop_s;
    logic [1:0]  lane_in_s;
    logic [3:0]  lane_bit_s;
    logic [31:0] byte_data_s;

    assign rise_s       = in_progress & ~in_prog_d_r;
    assign fall_s       = ~in_progress & in_prog_d_r;
    assign offset_s     = write_address - WIN_BASE;
    assign in_win_s     = ({1'b0, offset_s} < WIN_SIZE);
    assign byte_ok_s    = write_enable & in_win_s;
    assign range_drop_s = write_enable & ~in_win_s;
    assign lane_in_s    = SI_Endian ? (2'd3 - write_address[1:0]) : write_address[1:0];
    assign lane_bit_s   = 4'b0001 << lane_in_s;
    assign byte_data_s  = {24'd0, write_byte} << {lane_in_s, 3'b000};

    // Pack stage state
    logic             pack_valid_r, pack_valid_s;
    logic [29:0]      pack_addr_r, pack_addr_s;
    logic [31:0]      pack_data_r, pack_data_s;
    logic [3:0]       pack_mask_r, pack_mask_s;
    logic [CNT_W-1:0] idle_cnt_r;
    logic             idle_flush_s;
    logic             push_s;
    logic [31:0]      push_data_s;
    logic [3:0]       push_mask_s;

    assign idle_flush_s = pack_valid_r & ~write_enable & (idle_cnt_r == FLUSH_LAST);

    // FIFO state
    logic [29:0]      fifo_addr_r [FIFO_DEPTH];
    logic [31:0]      fifo_data_r [FIFO_DEPTH];
    logic [3:0]       fifo_mask_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
    logic [PTR_W:0]   count_r, count_s;
    logic             fifo_full_s, fifo_empty_s, push_ok_s, overflow_set_s;
    logic             pop_s;

    assign fifo_full_s    = (count_r == FIFO_FULL);
    assign fifo_empty_s   = (count_r == '0);
    assign push_ok_s      = push_s & (~fifo_full_s | pop_s);
    assign overflow_set_s = push_s & fifo_full_s & ~pop_s;

    // Next pack contents and the entry leaving the pack this cycle
    always_comb begin
        pack_valid_s = pack_valid_r;
        pack_addr_s  = pack_addr_r;
        pack_data_s  = pack_data_r;
        pack_mask_s  = pack_mask_r;
        push_s       = 1'b0;
        push_data_s  = pack_data_r;
        push_mask_s  = pack_mask_r;
        if (byte_ok_s) begin
            if (pack_valid_r && (pack_addr_r == write_address[31:2]) &&
                ((pack_mask_r & lane_bit_s) == 4'b0000)) begin
                if ((pack_mask_r | lane_bit_s) == 4'b1111) begin
                    push_s       = 1'b1;
                    push_data_s  = pack_data_r | byte_data_s;
                    push_mask_s  = 4'b1111;
                    pack_valid_s = 1'b0;
                    pack_mask_s  = 4'b0000;
                end else begin
                    pack_data_s = pack_data_r | byte_data_s;
                    pack_mask_s = pack_mask_r | lane_bit_s;
                end
            end else begin
                push_s       = pack_valid_r;
                pack_valid_s = 1'b1;
                pack_addr_s  = write_address[31:2];
                pack_data_s  = byte_data_s;
                pack_mask_s  = lane_bit_s;
            end
        end else if (pack_valid_r && (fall_s || idle_flush_s)) begin
            push_s       = 1'b1;
            pack_valid_s = 1'b0;
            pack_mask_s  = 4'b0000;
        end else begin
            push_s = 1'b0;
        end
    end

    // Pack register and idle counter
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            pack_valid_r <= 1'b0;
            pack_addr_r  <= 30'd0;
            pack_data_r  <= 32'd0;
            pack_mask_r  <= 4'b0000;
            idle_cnt_r   <= '0;
            in_prog_d_r  <= 1'b0;
        end else begin
            pack_valid_r <= pack_valid_s;
            pack_addr_r  <= pack_addr_s;
            pack_data_r  <= pack_data_s;
            pack_mask_r  <= pack_mask_s;
            in_prog_d_r  <= in_progress;
            if (write_enable || !pack_valid_s) begin
                idle_cnt_r <= '0;
            end else begin
                idle_cnt_r <= idle_cnt_r + 1'b1;
            end
        end
    end

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge HCLK) begin
        if (push_ok_s) begin
            fifo_addr_r[wr_ptr_r] <= pack_addr_r;
            fifo_data_r[wr_ptr_r] <= push_data_s;
            fifo_mask_r[wr_ptr_r] <= push_mask_s;
        end
    end

    // Occupancy is adjusted by both ports in one step
    always_comb begin
        case ({push_ok_s, pop_s})
            2'b10:   count_s = count_r + 1'b1;
            2'b01:   count_s = count_r - 1'b1;
            default: count_s = count_r;
        endcase
    end

    // FIFO pointers and occupancy
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            count_r <= count_s;
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
        end
    end

    // Master FSM and current entry being replayed
    state_t      state_r, state_s;
    logic [29:0] cur_addr_r;
    logic [31:0] cur_data_r;
    logic [3:0]  cur_mask_r, rem_mask_s;
    logic [1:0]  cur_lane_r;
    logic        issue_s, xfer_done_s;
    logic [29:0] iss_addr_s;
    logic [31:0] iss_data_s;
    logic [3:0]  iss_mask_s;
    logic [1:0]  iss_lane_s, iss_off_s;
    logic        iss_word_s;
    logic [31:0] dat_word_s;
    logic [7:0]  cur_byte_s;

    logic [31:0] haddr_r, hwdata_r;
    logic [2:0]  hsize_r;
    logic [1:0]  htrans_r;
    logic        hwrite_r, bus_owner_r, overflow_err_r, range_err_r;
    logic [15:0] xfer_count_r;

    // A word entry is finished in one beat; byte entries drop one lane per beat
    assign rem_mask_s = (cur_mask_r == 4'b1111) ? 4'b0000
                                                : (cur_mask_r & ~(4'b0001 << cur_lane_r));
    assign iss_lane_s = low_lane(iss_mask_s);
    assign iss_off_s  = SI_Endian ? (2'd3 - iss_lane_s) : iss_lane_s;
    assign iss_word_s = (iss_mask_s == 4'b1111);
    assign cur_byte_s = cur_data_r[{cur_lane_r, 3'b000} +: 8];
    assign dat_word_s = (cur_mask_r == 4'b1111) ? cur_data_r : {4{cur_byte_s}};

    // Next state, FIFO pop and the entry feeding the next address phase
    always_comb begin
        state_s     = state_r;
        pop_s       = 1'b0;
        issue_s     = 1'b0;
        xfer_done_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s   = 1'b1;
                    issue_s = 1'b1;
                    state_s = ST_ADDR;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (HREADY) begin
                    state_s = ST_DATA;
                end else begin
                    state_s = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (HREADY) begin
                    xfer_done_s = 1'b1;
                    if (rem_mask_s != 4'b0000) begin
                        issue_s = 1'b1;
                        state_s = ST_ADDR;
                    end else if (!fifo_empty_s) begin
                        pop_s   = 1'b1;
                        issue_s = 1'b1;
                        state_s = ST_ADDR;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    state_s = ST_DATA;
                end
            end
            default: state_s = ST_IDLE;
        endcase
        if (pop_s) begin
            iss_addr_s = fifo_addr_r[rd_ptr_r];
            iss_data_s = fifo_data_r[rd_ptr_r];
            iss_mask_s = fifo_mask_r[rd_ptr_r];
        end else begin
            iss_addr_s = cur_addr_r;
            iss_data_s = cur_data_r;
            iss_mask_s = rem_mask_s;
        end
    end

    // FSM state, current entry and registered AHB outputs
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_r    <= ST_IDLE;
            cur_addr_r <= 30'd0;
            cur_data_r <= 32'd0;
            cur_mask_r <= 4'b0000;
            cur_lane_r <= 2'd0;
            haddr_r    <= 32'd0;
            hsize_r    <= 3'b000;
            htrans_r   <= 2'b00;
            hwrite_r   <= 1'b0;
            hwdata_r   <= 32'd0;
        end else begin
            state_r <= state_s;
            if (issue_s) begin
                cur_addr_r <= iss_addr_s;
                cur_data_r <= iss_data_s;
                cur_mask_r <= iss_mask_s;
                cur_lane_r <= iss_lane_s;
                haddr_r    <= iss_word_s ? {iss_addr_s, 2'b00} : {iss_addr_s, iss_off_s};
                hsize_r    <= iss_word_s ? 3'b010 : 3'b000;
                htrans_r   <= 2'b10;
                hwrite_r   <= 1'b1;
            end else if ((state_r == ST_ADDR) && HREADY) begin
                htrans_r <= 2'b00;
                hwrite_r <= 1'b0;
                hwdata_r <= dat_word_s;
            end
        end
    end

    // Status: sticky errors, transfer counter, bus ownership
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            overflow_err_r <= 1'b0;
            range_err_r    <= 1'b0;
            xfer_count_r   <= 16'd0;
            bus_owner_r    <= 1'b0;
        end else begin
            overflow_err_r <= (overflow_err_r & ~rise_s) | overflow_set_s;
            range_err_r    <= (range_err_r & ~rise_s) | range_drop_s;
            if (rise_s) begin
                xfer_count_r <= 16'd0;
            end else if (xfer_done_s) begin
                xfer_count_r <= xfer_count_r + 16'd1;
            end
            bus_owner_r <= in_progress | pack_valid_s | (count_s != '0) | (state_s != ST_IDLE);
        end
    end

    assign HADDR        = haddr_r;
    assign HBURST       = 3'b000;
    assign HMASTLOCK    = 1'b0;
    assign HPROT        = 4'b0011;
    assign HSIZE        = hsize_r;
    assign HTRANS       = htrans_r;
    assign HWDATA       = hwdata_r;
    assign HWRITE       = hwrite_r;
    assign bus_owner    = bus_owner_r;
    assign overflow_err = overflow_err_r;
    assign range_err    = range_err_r;
    assign xfer_count   = xfer_count_r;

endmodule

// File: tb/tb_mfp_srec_ahb_loader_master.sv
// Scoreboard bench for mfp_srec_ahb_loader_master: a byte-level reference
// model predicts AHB transfers; a monitor pops and compares them.
module tb_mfp_srec_ahb_loader_master;
    localparam int          FIFO_DEPTH   = 8;
    localparam logic [31:0] WIN_BASE     = 32'h0000_0100;
    localparam int          WIN_LOG2     = 12;
    localparam int          FLUSH_CYCLES = 8;

    logic        HCLK, HRESET, SI_Endian, in_progress, write_enable, HREADY;
    logic [31:0] write_address;
    logic [7:0]  write_byte;
    logic [31:0] HADDR, HWDATA;
    logic [2:0]  HBURST, HSIZE;
    logic        HMASTLOCK, HWRITE, bus_owner, overflow_err, range_err;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    logic [15:0] xfer_count;

    mfp_srec_ahb_loader_master #(
        .FIFO_DEPTH(FIFO_DEPTH), .WIN_BASE(WIN_BASE),
        .WIN_LOG2(WIN_LOG2), .FLUSH_CYCLES(FLUSH_CYCLES)
    ) dut (
        .HCLK(HCLK), .HRESET(HRESET), .SI_Endian(SI_Endian), .in_progress(in_progress),
        .write_address(write_address), .write_byte(write_byte), .write_enable(write_enable),
        .HREADY(HREADY), .HADDR(HADDR), .HBURST(HBURST), .HMASTLOCK(HMASTLOCK),
        .HPROT(HPROT), .HSIZE(HSIZE), .HTRANS(HTRANS), .HWDATA(HWDATA), .HWRITE(HWRITE),
        .bus_owner(bus_owner), .overflow_err(overflow_err), .range_err(range_err),
        .xfer_count(xfer_count)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] data;
    } xfer_t;

    xfer_t exp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    bit    hr_rand = 1'b0;

    // reference model state: pending bytes keyed by byte offset within the word
    bit          m_valid, m_be, m_range;
    logic [29:0] m_word;
    bit          m_has[4];
    logic [7:0]  m_byte[4];
    int          m_xfers;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_emit();
        xfer_t       x;
        logic [31:0] w;
        if (m_has[0] && m_has[1] && m_has[2] && m_has[3]) begin
            w = 32'd0;
            for (int o = 0; o < 4; o++) begin
                int ln;
                ln = m_be ? 3 - o : o;
                w[ln*8 +: 8] = m_byte[o];
            end
            x.addr = {m_word, 2'b00}; x.size = 3'b010; x.data = w;
            exp_q.push_back(x);
            m_xfers++;
        end else begin
            for (int ln = 0; ln < 4; ln++) begin
                int o;
                o = m_be ? 3 - ln : ln;
                if (m_has[o]) begin
                    x.addr = {m_word, 2'b00} + 32'(o);
                    x.size = 3'b000;
                    x.data = {4{m_byte[o]}};
                    exp_q.push_back(x);
                    m_xfers++;
                end
            end
        end
        m_valid = 1'b0;
        for (int o = 0; o < 4; o++) m_has[o] = 1'b0;
    endtask

    task automatic model_byte(input logic [31:0] a, input logic [7:0] d);
        longint unsigned la, lo, hi;
        int o;
        la = a; lo = WIN_BASE; hi = lo + (64'd1 << WIN_LOG2);
        o  = int'(a[1:0]);
        if (la < lo || la >= hi) begin
            m_range = 1'b1;
        end else if (m_valid && m_word == a[31:2] && !m_has[o]) begin
            m_has[o] = 1'b1; m_byte[o] = d;
            if (m_has[0] && m_has[1] && m_has[2] && m_has[3]) model_emit();
        end else begin
            if (m_valid) model_emit();
            m_valid = 1'b1; m_word = a[31:2]; m_has[o] = 1'b1; m_byte[o] = d;
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic send_raw(input logic [31:0] a, input logic [7:0] d);
        write_address = a; write_byte = d; write_enable = 1'b1;
        step();
        write_enable = 1'b0;
    endtask

    task automatic send_byte(input logic [31:0] a, input logic [7:0] d);
        model_byte(a, d);
        send_raw(a, d);
    endtask

    task automatic start_batch(input bit be);
        in_progress = 1'b0;
        step();
        SI_Endian = be; m_be = be; in_progress = 1'b1;
        m_xfers = 0; m_range = 1'b0;
        step();
    endtask

    task automatic end_batch(input bit use_fall);
        if (m_valid) model_emit();
        if (use_fall) begin
            in_progress = 1'b0;
            step();
        end else begin
            repeat (FLUSH_CYCLES + 3) step();
        end
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 400) begin
            step();
            t++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL %s_drain: %0d transfers outstanding, expected 0", name, exp_q.size());
            exp_q.delete();
        end
        step(); step();
        check({name, "_xfer_count"}, 32'(xfer_count), 32'(m_xfers));
        check({name, "_range_err"}, 32'(range_err), 32'(m_range));
        check({name, "_overflow_err"}, 32'(overflow_err), 32'd0);
    endtask

    // free-running random HREADY for the randomized phase
    initial begin
        forever begin
            @(posedge HCLK);
            #1;
            if (hr_rand) HREADY = ($urandom_range(0, 3) != 0);
        end
    end

    // monitor: hold checks during wait states, scoreboard pop at data-phase completion
    bit          aw, dp, dw;
    logic [31:0] aw_addr, dp_addr, dw_data;
    logic [2:0]  dp_size;
    always @(negedge HCLK) begin
        if (HRESET) begin
            aw = 1'b0; dp = 1'b0; dw = 1'b0;
        end else begin
            if (aw) begin
                check("haddr_hold", HADDR, aw_addr);
                check("htrans_hold", 32'(HTRANS), 32'd2);
            end
            if (dp) begin
                if (dw) check("hwdata_hold", HWDATA, dw_data);
                if (HREADY) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_xfer: got addr 0x%08h data 0x%08h, expected none",
                                 dp_addr, HWDATA);
                    end else begin
                        xfer_t e;
                        e = exp_q.pop_front();
                        check("haddr", dp_addr, e.addr);
                        check("hsize", 32'(dp_size), 32'(e.size));
                        check("hwdata", HWDATA, e.data);
                    end
                    dp = 1'b0; dw = 1'b0;
                end else begin
                    dw = 1'b1; dw_data = HWDATA;
                end
            end
            aw = 1'b0;
            if (HTRANS == 2'b10) begin
                check("hwrite", 32'(HWRITE), 32'd1);
                if (HREADY) begin
                    dp = 1'b1; dw = 1'b0; dp_addr = HADDR; dp_size = HSIZE;
                end else begin
                    aw = 1'b1; aw_addr = HADDR;
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] oob[4];
        logic [31:0] a;
        int t;
        oob[0] = 32'h0000_00FF; oob[1] = 32'h0000_1100;
        oob[2] = 32'h0000_2000; oob[3] = 32'h0000_0000;
        HRESET = 1'b1; SI_Endian = 1'b0; in_progress = 1'b0; write_enable = 1'b0;
        write_address = 32'd0; write_byte = 8'd0; HREADY = 1'b1;
        m_valid = 1'b0; m_be = 1'b0; m_range = 1'b0; m_xfers = 0; m_word = 30'd0;
        for (int o = 0; o < 4; o++) begin m_has[o] = 1'b0; m_byte[o] = 8'd0; end
        repeat (3) step();
        HRESET = 1'b0;
        step();
        check("rst_htrans", 32'(HTRANS), 32'd0);
        check("rst_haddr", HADDR, 32'd0);
        check("rst_hprot", 32'(HPROT), 32'h3);
        check("rst_hwrite", 32'(HWRITE), 32'd0);
        check("rst_bus_owner", 32'(bus_owner), 32'd0);
        check("rst_xfer_count", 32'(xfer_count), 32'd0);

        // little-endian word, big-endian word, flushed single byte
        for (int be = 0; be < 2; be++) begin
            start_batch(be[0]);
            for (int i = 0; i < 4; i++) send_byte(32'h100 + 32'(i), 8'h11 * 8'(i + 1));
            end_batch(1'b1);
            drain(be == 0 ? "word_le" : "word_be");
        end
        start_batch(1'b0);
        send_byte(32'h205, 8'hAB);
        end_batch(1'b0);
        drain("byte_flush");

        // wait states: 3 cycles in address phase, 2 in data phase
        HREADY = 1'b0;
        start_batch(1'b0);
        for (int i = 0; i < 4; i++) send_byte(32'h300 + 32'(i), 8'($urandom));
        end_batch(1'b1);
        t = 0;
        while (HTRANS != 2'b10 && t < 20) begin step(); t++; end
        check("stall_addr_phase", 32'(HTRANS), 32'd2);
        repeat (3) step();
        HREADY = 1'b1; step();
        HREADY = 1'b0; step(); step();
        HREADY = 1'b1;
        drain("stall");

        // window boundaries: below base, last byte, past end, far outside
        start_batch(1'b1);
        send_byte(32'h0000_00FF, 8'h5A);
        send_byte(32'h0000_10FF, 8'hC3);
        send_byte(32'h0000_1100, 8'h77);
        send_byte(32'h0000_2000, 8'h99);
        end_batch(1'b1);
        drain("window");

        // randomized batches with random bus wait states
        hr_rand = 1'b1;
        for (int b = 0; b < 24; b++) begin
            start_batch(1'($urandom));
            for (int i = 0; i < int'($urandom_range(1, 6)); i++) begin
                if ($urandom_range(0, 7) == 0) a = oob[$urandom_range(0, 3)];
                else a = (($urandom_range(0, 1) == 0) ? 32'h100 : 32'h10F0)
                         + 32'($urandom_range(0, 2)) * 32'd4 + 32'($urandom_range(0, 3));
                send_byte(a, 8'($urandom));
                repeat ($urandom_range(0, 3)) step();
            end
            end_batch(1'($urandom));
            drain("random");
        end
        hr_rand = 1'b0;

        // overflow with a stalled bus, then clear on the in_progress rise
        HREADY = 1'b0;
        in_progress = 1'b0; step();
        in_progress = 1'b1; step();
        for (int w = 0; w < FIFO_DEPTH + 3; w++)
            for (int i = 0; i < 4; i++) send_raw(32'h400 + 32'(w * 4 + i), 8'($urandom));
        step();
        check("ovf_set", 32'(overflow_err), 32'd1);
        check("ovf_bus_owner", 32'(bus_owner), 32'd1);
        in_progress = 1'b0; step();
        in_progress = 1'b1; step(); step();
        check("ovf_cleared", 32'(overflow_err), 32'd0);
        check("ovf_held_addr", 32'(HTRANS), 32'd2);

        // reset during a held address phase
        HRESET = 1'b1; in_progress = 1'b0;
        step();
        check("rst_mid_htrans", 32'(HTRANS), 32'd0);
        check("rst_mid_bus_owner", 32'(bus_owner), 32'd0);
        HRESET = 1'b0; HREADY = 1'b1;
        repeat (4) step();
        check("rst_mid_idle", 32'(HTRANS), 32'd0);
        check("rst_mid_fifo_empty", 32'(bus_owner), 32'd0);
        check("rst_mid_count", 32'(xfer_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
